// File: rtl/trace_record_collector.sv
// Per-instruction pipeline trace collector: stamps stage entry/exit cycles into an in-order record buffer.
// Optional `TRACE_DROP_COUNT_EN adds drop_count_o, a saturating count of dropped allocations.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module trace_record_collector #(
    parameter int NUM_STAGES = 4,
    parameter int DEPTH      = 8,
    parameter int TIME_WIDTH = 32,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    localparam int REC_W = DATA_WIDTH + ADDR_WIDTH + 1 + 2 * NUM_STAGES * TIME_WIDTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stage_start_i,
    input  logic [NUM_STAGES-1:0] stage_end_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  pass_through_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [REC_W-1:0]      rec_data_o,
    output logic [OCC_W-1:0]      occupancy_o,
    output logic                  overflow_o,
`ifdef TRACE_DROP_COUNT_EN
    output logic [15:0]           drop_count_o,
`endif
    output logic                  err_o
);

    logic [TIME_WIDTH-1:0] cycle_cnt;
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W-1:0]      ptr [NUM_STAGES];
    logic [NUM_STAGES-1:0] busy;
    logic [NUM_STAGES-1:0] ended [DEPTH];

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
    logic                  pt_mem    [DEPTH];
    logic [TIME_WIDTH-1:0] start_mem [DEPTH][NUM_STAGES];
    logic [TIME_WIDTH-1:0] end_mem   [DEPTH][NUM_STAGES];

    logic [NUM_STAGES-1:0] end_ok, start_ok;
    logic [PTR_W-1:0]      start_tgt [NUM_STAGES];
    logic                  pop, alloc, drop, full, err_ev;

    always_comb begin
        pop    = rec_valid_o && rec_ready_i;
        full   = (occupancy_o == OCC_W'(DEPTH));
        end_ok = stage_end_i & busy;
        start_ok = '0;
        start_tgt[0] = tail;
        start_ok[0]  = stage_start_i[0] && (!busy[0] || end_ok[0]);
        // A later stage may open the slot that the previous stage closes in this same cycle.
        for (int i = 1; i < NUM_STAGES; i++) begin
            start_tgt[i] = end_ok[i] ? ptr[i] + PTR_W'(1) : ptr[i];
            start_ok[i]  = stage_start_i[i] && (!busy[i] || end_ok[i]) &&
                           (ended[start_tgt[i]][i-1] || (end_ok[i-1] && ptr[i-1] == start_tgt[i]));
        end
        alloc  = start_ok[0] && (!full || pop);
        drop   = start_ok[0] && !alloc;
        err_ev = |(stage_start_i & ~start_ok) || |(stage_end_i & ~end_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            head        <= '0;
            tail        <= '0;
            busy        <= '0;
            occupancy_o <= '0;
            overflow_o  <= 1'b0;
            err_o       <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) ptr[i] <= '0;
            for (int s = 0; s < DEPTH; s++) ended[s] <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + TIME_WIDTH'(1);
            head        <= head + PTR_W'(pop);
            tail        <= tail + PTR_W'(alloc);
            occupancy_o <= occupancy_o + OCC_W'(alloc) - OCC_W'(pop);
            overflow_o  <= overflow_o | drop;
            err_o       <= err_o | err_ev;
            if (pop) ended[head] <= '0;
            if (alloc) ended[tail] <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (end_ok[i]) begin
                    ended[ptr[i]][i] <= 1'b1;
                    ptr[i]           <= ptr[i] + PTR_W'(1);
                end
                if ((i == 0) ? alloc : start_ok[i]) busy[i] <= 1'b1;
                else if (end_ok[i])                 busy[i] <= 1'b0;
            end
        end
    end

    // Record payload: no reset needed, outputs are gated by rec_valid_o.
    always_ff @(posedge clk) begin
        if (alloc) begin
            instr_mem[start_tgt[0]]    <= instr_i;
            addr_mem[start_tgt[0]]     <= addr_i;
            pt_mem[start_tgt[0]]       <= pass_through_i;
            start_mem[start_tgt[0]][0] <= cycle_cnt;
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (end_ok[i]) end_mem[ptr[i]][i] <= cycle_cnt;
            if (i > 0 && start_ok[i]) start_mem[start_tgt[i]][i] <= cycle_cnt;
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_count_o <= '0;
        else if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
`endif

    assign rec_valid_o = (occupancy_o != '0) && ended[head][NUM_STAGES-1];

    always_comb begin
        rec_data_o = '0;
        if (rec_valid_o) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                rec_data_o[k*TIME_WIDTH +: TIME_WIDTH]                = end_mem[head][k];
                rec_data_o[(NUM_STAGES+k)*TIME_WIDTH +: TIME_WIDTH]   = start_mem[head][k];
            end
            rec_data_o[2*NUM_STAGES*TIME_WIDTH]                       = pt_mem[head];
            rec_data_o[2*NUM_STAGES*TIME_WIDTH+1 +: ADDR_WIDTH]       = addr_mem[head];
            rec_data_o[2*NUM_STAGES*TIME_WIDTH+1+ADDR_WIDTH +: DATA_WIDTH] = instr_mem[head];
        end
    end

endmodule

// File: tb/tb_trace_record_collector.sv
// Directed bench for trace_record_collector: a 32-bit and an 8-bit timestamp instance share stimulus.
module tb_trace_record_collector;

    localparam int N    = 4;
    localparam int TW   = 32;
    localparam int REC  = 32 + 32 + 1 + 2 * N * TW;
    localparam int REC8 = 32 + 32 + 1 + 2 * N * 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    stage_start = '0, stage_end = '0;
    logic [31:0]     instr = '0, addr = '0;
    logic            pt = 1'b0;
    logic            ready = 1'b0;
    logic            valid, valid8, ovf, ovf8, err, err8;
    logic [REC-1:0]  rec;
    logic [REC8-1:0] rec8;
    logic [3:0]      occ, occ8;
`ifdef TRACE_DROP_COUNT_EN
    logic [15:0]     drops, drops8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_record_collector #(.NUM_STAGES(N), .DEPTH(8), .TIME_WIDTH(32),
                             .DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .stage_start_i(stage_start), .stage_end_i(stage_end),
        .instr_i(instr), .addr_i(addr), .pass_through_i(pt),
        .rec_valid_o(valid), .rec_ready_i(ready), .rec_data_o(rec),
        .occupancy_o(occ), .overflow_o(ovf),
`ifdef TRACE_DROP_COUNT_EN
        .drop_count_o(drops),
`endif
        .err_o(err));

    trace_record_collector #(.NUM_STAGES(N), .DEPTH(8), .TIME_WIDTH(8),
                             .DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut8 (
        .clk(clk), .rst(rst), .stage_start_i(stage_start), .stage_end_i(stage_end),
        .instr_i(instr), .addr_i(addr), .pass_through_i(pt),
        .rec_valid_o(valid8), .rec_ready_i(ready), .rec_data_o(rec8),
        .occupancy_o(occ8), .overflow_o(ovf8),
`ifdef TRACE_DROP_COUNT_EN
        .drop_count_o(drops8),
`endif
        .err_o(err8));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] f_start(input int k);
        return rec[(N+k)*TW +: TW];
    endfunction
    function automatic logic [31:0] f_end(input int k);
        return rec[k*TW +: TW];
    endfunction

    task automatic step(input logic [N-1:0] s, input logic [N-1:0] e);
        stage_start = s;
        stage_end   = e;
        @(negedge clk);
        stage_start = '0;
        stage_end   = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // n instructions, every stage one cycle long, stage hand-off on the same edge.
    task automatic run_pipe(input int n, input logic [31:0] base);
        logic [N-1:0] s, e;
        for (int c = 0; c < n + N; c++) begin
            s = '0;
            e = '0;
            for (int k = 0; k < N; k++) begin
                s[k] = (c - k >= 0) && (c - k < n);
                e[k] = (c - k - 1 >= 0) && (c - k - 1 < n);
            end
            if (s[0]) begin
                instr = base + 32'(c);
                addr  = 32'h4000 + 32'(c);
                pt    = c[0];
            end
            step(s, e);
        end
    endtask

    int cnt;

    initial begin
        @(negedge clk);
        do_reset();
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_occ", 64'(occ), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_data", 64'(rec != '0), 64'd0);

        // Single instruction: stages at 10/11, 11/12, 12/14, 14/15
        ready = 1'b1;
        idle(10);
        instr = 32'hDEADBEEF;
        addr  = 32'h00001234;
        pt    = 1'b1;
        step(4'b0001, 4'b0000);
        check_eq("t1_occ_alloc", 64'(occ), 64'd1);
        step(4'b0010, 4'b0001);
        step(4'b0100, 4'b0010);
        step(4'b0000, 4'b0000);
        step(4'b1000, 4'b0100);
        check_eq("t1_valid_early", 64'(valid), 64'd0);
        step(4'b0000, 4'b1000);
        check_eq("t1_valid", 64'(valid), 64'd1);
        check_eq("t1_instr", 64'(rec[REC-1 -: 32]), 64'hDEADBEEF);
        check_eq("t1_addr", 64'(rec[2*N*TW+1 +: 32]), 64'h1234);
        check_eq("t1_pt", 64'(rec[2*N*TW]), 64'd1);
        check_eq("t1_s0", 64'(f_start(0)), 64'd10);
        check_eq("t1_s1", 64'(f_start(1)), 64'd11);
        check_eq("t1_s2", 64'(f_start(2)), 64'd12);
        check_eq("t1_s3", 64'(f_start(3)), 64'd14);
        check_eq("t1_e0", 64'(f_end(0)), 64'd11);
        check_eq("t1_e1", 64'(f_end(1)), 64'd12);
        check_eq("t1_e2", 64'(f_end(2)), 64'd14);
        check_eq("t1_e3", 64'(f_end(3)), 64'd15);
        step('0, '0);
        check_eq("t1_occ_after", 64'(occ), 64'd0);
        check_eq("t1_valid_after", 64'(valid), 64'd0);
        check_eq("t1_err", 64'(err), 64'd0);

        // Three instructions back-to-back, held until drained
        do_reset();
        ready = 1'b0;
        run_pipe(3, 32'h200);
        check_eq("t2_occ", 64'(occ), 64'd3);
        check_eq("t2_err", 64'(err), 64'd0);
        for (int j = 0; j < 3; j++) begin
            check_eq($sformatf("t2_valid%0d", j), 64'(valid), 64'd1);
            check_eq($sformatf("t2_instr%0d", j), 64'(rec[REC-1 -: 32]), 64'(32'h200 + j));
            check_eq($sformatf("t2_pt%0d", j), 64'(rec[2*N*TW]), 64'(j % 2));
            for (int k = 0; k < N; k++) begin
                check_eq($sformatf("t2_s%0d_%0d", j, k), 64'(f_start(k)), 64'(j + k));
                check_eq($sformatf("t2_e%0d_%0d", j, k), 64'(f_end(k)), 64'(j + k + 1));
            end
            ready = 1'b1;
            step('0, '0);
            ready = 1'b0;
        end
        check_eq("t2_occ_end", 64'(occ), 64'd0);

        // Overflow: eight buffered, ninth dropped
        do_reset();
        run_pipe(8, 32'h300);
        check_eq("t3_occ_full", 64'(occ), 64'd8);
        check_eq("t3_ovf_before", 64'(ovf), 64'd0);
        step(4'b0001, 4'b0000);
        check_eq("t3_occ_drop", 64'(occ), 64'd8);
        check_eq("t3_ovf", 64'(ovf), 64'd1);
        check_eq("t3_err", 64'(err), 64'd0);
`ifdef TRACE_DROP_COUNT_EN
        check_eq("t3_drop_count", 64'(drops), 64'd1);
`endif
        check_eq("t3_first_instr", 64'(rec[REC-1 -: 32]), 64'h300);
        ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) cnt++;
            step('0, '0);
        end
        ready = 1'b0;
        check_eq("t3_records", 64'(cnt), 64'd8);
        check_eq("t3_occ_end", 64'(occ), 64'd0);

        // Protocol violations
        do_reset();
        step(4'b0000, 4'b0100);
        check_eq("t4_err_end", 64'(err), 64'd1);
        check_eq("t4_occ_end", 64'(occ), 64'd0);
        check_eq("t4_valid_end", 64'(valid), 64'd0);
        do_reset();
        step(4'b0001, 4'b0000);
        check_eq("t4_err_clean", 64'(err), 64'd0);
        step(4'b0010, 4'b0000);
        check_eq("t4_err_start", 64'(err), 64'd1);
        check_eq("t4_occ_start", 64'(occ), 64'd1);

        // Timestamp wrap on the 8-bit instance: 510 mod 256 = 254
        do_reset();
        idle(510);
        run_pipe(1, 32'h500);
        check_eq("t5_err8", 64'(err8), 64'd0);
        check_eq("t5_valid8", 64'(valid8), 64'd1);
        check_eq("t5_s0", 64'(rec8[(N+0)*8 +: 8]), 64'd254);
        check_eq("t5_s1", 64'(rec8[(N+1)*8 +: 8]), 64'd255);
        check_eq("t5_s2", 64'(rec8[(N+2)*8 +: 8]), 64'd0);
        check_eq("t5_e0", 64'(rec8[0 +: 8]), 64'd255);
        check_eq("t5_e3", 64'(rec8[3*8 +: 8]), 64'd2);
        check_eq("t5_s0_wide", 64'(f_start(0)), 64'd510);

        // Asynchronous reset with records buffered
        do_reset();
        run_pipe(3, 32'h600);
        step(4'b0000, 4'b0100);
        check_eq("t6_occ_before", 64'(occ), 64'd3);
        check_eq("t6_err_before", 64'(err), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_valid", 64'(valid), 64'd0);
        check_eq("t6_occ", 64'(occ), 64'd0);
        check_eq("t6_err", 64'(err), 64'd0);
        check_eq("t6_data", 64'(rec != '0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_pipe(1, 32'hA0);
        check_eq("t6_occ_new", 64'(occ), 64'd1);
        check_eq("t6_instr_new", 64'(rec[REC-1 -: 32]), 64'hA0);
        check_eq("t6_s0_new", 64'(f_start(0)), 64'd0);
        check_eq("t6_e3_new", 64'(f_end(3)), 64'd4);
        ready = 1'b1;
        step('0, '0);
        check_eq("t6_occ_drained", 64'(occ), 64'd0);
        check_eq("t6_valid_drained", 64'(valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
